// File: rtl/shift_register_scheduler.sv
// shift_register_scheduler: round-robin sharing of one word-serializing shift register among N requesters
module shift_register_scheduler #(
  parameter int B = 8,
  parameter int L = 4,
  parameter int N = 4,
  localparam int W = B * L,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    ack,
  output logic [W-1:0]    sr_data_in,
  output logic            sr_we,
  input  logic            sr_empty,
  output logic            busy,
  output logic [IW-1:0]   grant_id
);
  typedef enum logic [1:0] {IDLE, LOAD, GUARD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win, idx;
  logic [W-1:0] sr_data_q, sr_data_d;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    sr_data_d = sr_data_q;
    win = rr_ptr_q;
    idx = '0;
    // scan downward so the lowest offset from rr_ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr_q) + k) % N);
      if (req[idx]) win = idx;
    end
    case (state_q)
      IDLE: if (sr_empty && |req) begin
        state_d = LOAD;
        grant_id_d = win;
        sr_data_d = req_data[win*W +: W];
      end
      LOAD: begin
        state_d = GUARD;
        rr_ptr_d = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;
      end
      GUARD: state_d = DRAIN;
      DRAIN: state_d = sr_empty ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      sr_data_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      sr_data_q <= sr_data_d;
    end
  end
  assign sr_we = (state_q == LOAD) && !reset;
  assign ack = sr_we ? N'(1) << grant_id_q : '0;
  assign busy = state_q != IDLE;
  assign sr_data_in = sr_data_q;
  assign grant_id = grant_id_q;
endmodule

// File: tb/tb_shift_register_scheduler.sv
// tb_shift_register_scheduler: directed checks of grant order, latency, reset and blocking behaviour
module tb_shift_register_scheduler;
  localparam int B = 8, L = 4, N = 4, W = B * L, IW = 2;
  logic clk = 0, reset = 1, sr_empty, sr_we, busy, ext_block = 0;
  logic [N-1:0] req = '0, ack;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] sr_data_in;
  logic [IW-1:0] grant_id;
  logic [3:0] cnt;
  int total = 0, bad = 0;
  int exp_order [5] = '{1, 2, 3, 0, 1};

  shift_register_scheduler #(.B(B), .L(L), .N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .sr_data_in(sr_data_in), .sr_we(sr_we), .sr_empty(sr_empty), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // serializer model: empty drops the cycle after the strobe, drains L bytes
  always @(posedge clk)
    if (reset) cnt <= 0;
    else if (sr_we) cnt <= 4'(L);
    else if (cnt != 0) cnt <= cnt - 1;
  assign sr_empty = (cnt == 0) && !ext_block;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_we();
    int n = 0;
    do begin cyc(); n++; end while (!sr_we && n < 30);
    chk("we_timeout", 32'(sr_we), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin cyc(); n++; end while (busy && n < 30);
    chk("idle_timeout", 32'(busy), 32'd0);
    chk("idle_empty", 32'(sr_empty), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_we"}, 32'(sr_we), 0);
    chk({tag, "_gid"}, 32'(grant_id), 0);
  endtask

  always @(negedge clk)
    if (sr_we) begin
      total++;
      assert (sr_empty === 1'b1 && $onehot(ack)) else begin
        bad++;
        $error("FAIL strobe_guard observed empty=%b ack=%b expected empty=1 onehot ack", sr_empty, ack);
      end
    end

  initial begin
    cyc(); cyc();
    chk_reset_vals("rst");
    chk("rst_data", sr_data_in, 0);
    reset = 0;
    req = 4'b0100;
    req_data[95:64] = 32'haabbccdd;
    cyc();
    chk("single_we", 32'(sr_we), 1);
    chk("single_ack", 32'(ack), 32'b0100);
    chk("single_data", sr_data_in, 32'haabbccdd);
    chk("single_gid", 32'(grant_id), 2);
    chk("single_busy", 32'(busy), 1);
    req = 0;
    cyc();
    chk("guard_we", 32'(sr_we), 0);
    chk("guard_busy", 32'(busy), 1);
    chk("guard_hold", sr_data_in, 32'haabbccdd);
    wait_idle();
    // rr_ptr is now 3: only client 0 requesting must wrap to 0
    req_data[31:0] = 32'h11111111;
    req = 4'b0001;
    wait_we();
    chk("wrap_gid", 32'(grant_id), 0);
    chk("wrap_ack", 32'(ack), 32'b0001);
    chk("wrap_data", sr_data_in, 32'h11111111);
    req = 0;
    wait_idle();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hc0de0000 + 32'(i);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_we();
      chk("rr_gid", 32'(grant_id), 32'(exp_order[i]));
      chk("rr_ack", 32'(ack), 32'(1) << exp_order[i]);
      chk("rr_data", sr_data_in, 32'hc0de0000 + 32'(exp_order[i]));
      if (i == 4) req = 0;
    end
    wait_idle();
    // reset while in GUARD; rr_ptr must restart at 0
    req = 4'b0100;
    wait_we();
    chk("g_gid", 32'(grant_id), 2);
    req = 0;
    cyc();
    reset = 1;
    cyc();
    chk_reset_vals("rst_guard");
    reset = 0;
    req = 4'b1010;
    wait_we();
    chk("post_guard_gid", 32'(grant_id), 1);
    chk("post_guard_ack", 32'(ack), 32'b0010);
    req = 0;
    cyc(); cyc();
    chk("drain_busy", 32'(busy), 1);
    reset = 1;
    cyc();
    chk_reset_vals("rst_drain");
    reset = 0;
    req = 4'b1001;
    wait_we();
    chk("post_drain_gid", 32'(grant_id), 0);
    // withdrawal: client 1 would win from rr_ptr=1 but drops before IDLE
    req = 0;
    cyc(); cyc();
    req = 4'b0110;
    cyc();
    req = 4'b0100;
    wait_we();
    chk("wd_gid", 32'(grant_id), 2);
    chk("wd_ack", 32'(ack), 32'b0100);
    req = 0;
    wait_idle();
    ext_block = 1;
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("blocked_we", 32'(sr_we), 0);
    end
    ext_block = 0;
    cyc();
    chk("unblock_we", 32'(sr_we), 1);
    chk("unblock_ack", 32'(ack), 32'b0010);
    req = 0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_register_scheduler.md
# shift_register_scheduler

Round-robin scheduler that shares one word-serializing shift register between N requesters. Each requester presents a B*L-bit word. The scheduler picks one requester whenever the serializer is empty, loads the word with a single-cycle write strobe, and acknowledges the requester. It then waits for the serializer to drain before granting again. It sits between the producer clients (command/status generators) and the byte-serial output path.

## Interface
Parameters:
- B, 8, byte width of serializer output
- L, 4, bytes per word; word width W = B*L
- N, 4, number of requesters (N >= 2); index width IW = $clog2(N)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N  request per client; held high with stable data until ack
- req_data  in  N*W  word of client i in bits [i*W +: W]
- ack  out  N  one-cycle pulse to the granted client, coincident with sr_we
- sr_data_in  out  W  word to serializer, registered
- sr_we  out  1  one-cycle load strobe to serializer
- sr_empty  in  1  serializer has no pending bytes
- busy  out  1  high from LOAD through end of DRAIN
- grant_id  out  IW  index of last granted client

## Operation
- States: IDLE, LOAD, GUARD, DRAIN.
- IDLE: when sr_empty=1 and req != 0, the scheduler does the following at the clock edge:
  - Selects the winner as the first set req bit at or after rr_ptr, searching upward modulo N.
  - Latches the winner's word into sr_data_in and the winner into grant_id.
  - Moves to LOAD.
- IDLE with sr_empty=0 or req=0: stays in IDLE and grants nothing.
- LOAD, exactly one cycle:
  - sr_we=1 and ack[grant_id]=1.
  - rr_ptr <= (grant_id+1) mod N.
  - Next state is GUARD.
- GUARD, exactly one cycle, ignores sr_empty. Serializer contract: empty deasserts no later than the cycle after the cycle in which sr_we is sampled. Next state is DRAIN.
- DRAIN: stays in DRAIN while sr_empty=0. Returns to IDLE on sr_empty=1.
- Requests that change while in LOAD, GUARD or DRAIN are ignored until IDLE.
- Withdrawal: a client dropping req before ack is legal. Arbitration uses only the req value in the IDLE decision cycle.
- A client holding req high after ack is treated as a new request. Round-robin guarantees that every other requesting client is served before it is served again.
- sr_data_in holds its value after LOAD, until the next grant.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0.
  - ack=0, sr_we=0, busy=0.
  - sr_data_in=0, grant_id=0.
- Request-to-strobe latency is one cycle. With req sampled high in IDLE at edge k, sr_we and ack are high in cycle k+1.
- busy is 1 in LOAD, GUARD and DRAIN, and 0 in IDLE.
- Minimum grant-to-grant spacing is 3 cycles plus the serializer drain time. The next grant's LOAD occurs at the earliest one cycle after the IDLE cycle in which sr_empty=1 is seen.
- Simultaneous requests resolve by round-robin in a single cycle. There is no starvation: the maximum wait is N-1 grants.
- Wrap-around: with rr_ptr=N-1 and only req[0] set, client 0 is granted. After granting client N-1, rr_ptr becomes 0.
- Reset asserted mid-operation (any state): the next cycle is IDLE with all outputs at their reset values. No sr_we or ack is issued in the reset cycle. A word already loaded into the serializer is not recalled; the serializer is reset by the same reset.
- sr_empty=0 at any time in IDLE (serializer occupied externally) blocks all grants.

## Test plan
- Single request:
  - Stimulus: N=4, reset 2 cycles, then req=4'b0100 with req_data[95:64]=32'haabbccdd. The serializer drains in 4 bytes.
  - Required response: one cycle later sr_we=1, ack=4'b0100, sr_data_in=32'haabbccdd, grant_id=2.
  - busy stays high until sr_empty returns to 1. rr_ptr becomes 3.
- Simultaneous requests:
  - Stimulus: req=4'b1111 held continuously.
  - Required response: grants in order 0,1,2,3,0. Exactly one ack bit per LOAD. No sr_we while sr_empty=0.
- Wrap-around:
  - Stimulus: after granting client 3, raise only req=4'b0001.
  - Required response: client 0 is granted and grant_id=0.
- Withdrawal:
  - Stimulus: client 1 raises req during DRAIN, then drops it before IDLE. Client 2 is requesting.
  - Required response: client 2 is granted; no ack to client 1.
- Reset mid-operation:
  - Stimulus: assert reset in GUARD and in DRAIN (two runs).
  - Required response: the following cycle has busy=0, ack=0, sr_we=0, grant_id=0. The first request after reset is granted by the rr_ptr=0 ordering.
- Blocked IDLE:
  - Stimulus: hold sr_empty=0 with req=4'b0010 for 10 cycles, then set sr_empty=1.
  - Required response: no sr_we during the 10 cycles; sr_we and ack[1] one cycle after sr_empty rises.
